lpc_host_encoder: RTL and testbench

//  LPC host-side cycle generator: the transmit end of the LPC bus the sniffer decodes.

---
 rtl/lpc_pkg.sv | 27 ++
 rtl/lpc_host_encoder.sv | 194 +++++++++++++++++++
 tb/tb_lpc_host_encoder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC definitions: cycle types, SYNC codes, response status codes and
// the host encoder state encoding.
package lpc_pkg;

    localparam logic [1:0] CT_IO  = 2'b00;
    localparam logic [1:0] CT_MEM = 2'b01;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;

    localparam logic [1:0] STAT_OK       = 2'd0;
    localparam logic [1:0] STAT_UNSUP    = 2'd1;
    localparam logic [1:0] STAT_SYNC_ERR = 2'd2;
    localparam logic [1:0] STAT_ABORT    = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_TAR1, S_TAR2,
        S_SYNC, S_RDATA, S_TARB1, S_TARB2, S_ABORT, S_DONE
    } lpc_state_t;

    function automatic logic cyctype_supported(input logic [1:0] ctype);
        return (ctype == CT_IO) || (ctype == CT_MEM);
    endfunction

endpackage

// File: rtl/lpc_host_encoder.sv
// LPC host cycle generator: turns one command record into a complete LPC bus
// cycle and reports read data and completion status.
module lpc_host_encoder
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in,
    output logic        lpc_frame,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [1:0]  resp_status
);

    localparam int TMO_W = $clog2(SYNC_TIMEOUT + 1);

    lpc_state_t       state_reg, state_next;
    logic [2:0]       nib_reg, nib_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [7:0]       rd_reg, rd_next;
    logic [1:0]       st_reg, st_next;
    logic [31:0]      addr_reg;
    logic [7:0]       wdata_reg;
    logic [1:0]       type_reg;
    logic             dir_reg;
    logic             accept;
    logic             unused_bits;

    logic [3:0]       ad_next;
    logic             oe_next;
    logic             frame_next;

    assign accept      = cmd_valid & cmd_ready;
    assign unused_bits = ^{cmd_data[7:4], cmd_data[0]};

    always_comb begin
        state_next = state_reg;
        nib_next   = nib_reg;
        tmo_next   = tmo_reg;
        rd_next    = rd_reg;
        st_next    = st_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    rd_next = 8'h00;
                    if (cyctype_supported(cmd_data[3:2])) begin
                        st_next    = STAT_OK;
                        state_next = S_START;
                    end else begin
                        st_next    = STAT_UNSUP;
                        state_next = S_DONE;
                    end
                end
            end
            S_START:   state_next = S_CYCTYPE;
            S_CYCTYPE: begin
                state_next = S_ADDR;
                nib_next   = (type_reg == CT_MEM) ? 3'd7 : 3'd3;
            end
            S_ADDR: begin
                if (nib_reg == 3'd0) begin
                    state_next = dir_reg ? S_WDATA : S_TAR1;
                end else begin
                    nib_next = nib_reg - 3'd1;
                end
            end
            S_WDATA: begin
                // nib_reg is 0 on entry from ADDR, so low nibble goes first
                if (nib_reg[0]) state_next = S_TAR1;
                else            nib_next   = 3'd1;
            end
            S_TAR1: state_next = S_TAR2;
            S_TAR2: begin
                state_next = S_SYNC;
                tmo_next   = '0;
            end
            S_SYNC: begin
                if (lpc_ad_in == SYNC_READY) begin
                    st_next    = STAT_OK;
                    nib_next   = 3'd0;
                    state_next = dir_reg ? S_TARB1 : S_RDATA;
                end else if (lpc_ad_in == SYNC_ERR) begin
                    st_next    = STAT_SYNC_ERR;
                    state_next = S_TARB1;
                end else if (tmo_reg == TMO_W'(SYNC_TIMEOUT - 1)) begin
                    st_next    = STAT_ABORT;
                    nib_next   = 3'd0;
                    state_next = S_ABORT;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            S_RDATA: begin
                if (nib_reg[0]) begin
                    rd_next[7:4] = lpc_ad_in;
                    state_next   = S_TARB1;
                end else begin
                    rd_next[3:0] = lpc_ad_in;
                    nib_next     = 3'd1;
                end
            end
            S_TARB1: state_next = S_TARB2;
            S_TARB2: state_next = S_DONE;
            S_ABORT: begin
                if (nib_reg == 3'd3) state_next = S_DONE;
                else                 nib_next   = nib_reg + 3'd1;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus pins are registered from the next state so they line up with state_reg.
    always_comb begin
        ad_next    = 4'hF;
        oe_next    = 1'b0;
        frame_next = 1'b1;
        unique case (state_next)
            S_START: begin
                ad_next    = 4'h0;
                oe_next    = 1'b1;
                frame_next = 1'b0;
            end
            S_CYCTYPE: begin
                ad_next = {type_reg, dir_reg, 1'b0};
                oe_next = 1'b1;
            end
            S_ADDR: begin
                ad_next = addr_reg[{nib_next, 2'b00} +: 4];
                oe_next = 1'b1;
            end
            S_WDATA: begin
                ad_next = nib_next[0] ? wdata_reg[7:4] : wdata_reg[3:0];
                oe_next = 1'b1;
            end
            S_TAR1:  oe_next = 1'b1;
            S_ABORT: begin
                oe_next    = 1'b1;
                frame_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            nib_reg     <= 3'd0;
            tmo_reg     <= '0;
            rd_reg      <= 8'h00;
            st_reg      <= STAT_OK;
            addr_reg    <= 32'h0;
            wdata_reg   <= 8'h00;
            type_reg    <= CT_IO;
            dir_reg     <= 1'b0;
            cmd_ready   <= 1'b0;
            lpc_ad_out  <= 4'hF;
            lpc_ad_oe   <= 1'b0;
            lpc_frame   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_data   <= 8'h00;
            resp_status <= STAT_OK;
        end else begin
            state_reg  <= state_next;
            nib_reg    <= nib_next;
            tmo_reg    <= tmo_next;
            rd_reg     <= rd_next;
            st_reg     <= st_next;
            if (accept) begin
                addr_reg  <= cmd_data[47:16];
                wdata_reg <= cmd_data[15:8];
                type_reg  <= cmd_data[3:2];
                dir_reg   <= cmd_data[1];
            end
            cmd_ready  <= (state_next == S_IDLE);
            lpc_ad_out <= ad_next;
            lpc_ad_oe  <= oe_next;
            lpc_frame  <= frame_next;
            resp_valid <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                resp_data   <= rd_next;
                resp_status <= st_next;
            end
        end
    end

endmodule

// File: tb/tb_lpc_host_encoder.sv
// Self-checking bench for lpc_host_encoder: a trace model builds the expected
// per-clock bus activity of each command plus the peripheral's replies.
module tb_lpc_host_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [47:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in;
    logic        lpc_frame;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_status;

    int checks = 0;
    int errors = 0;

    // Expected {frame, oe, ad} per bus clock after accept, and the LAD value
    // the peripheral drives in that clock.
    logic [5:0] exp_q[$];
    logic [3:0] drv_q[$];
    logic [7:0] exp_data;
    logic [1:0] exp_status;

    localparam int FIN_READY   = 0;
    localparam int FIN_ERR     = 1;
    localparam int FIN_TIMEOUT = 2;

    lpc_host_encoder #(.SYNC_TIMEOUT(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .lpc_ad_out  (lpc_ad_out),
        .lpc_ad_oe   (lpc_ad_oe),
        .lpc_ad_in   (lpc_ad_in),
        .lpc_frame   (lpc_frame),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_status (resp_status)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic f, input logic o, input logic [3:0] a,
                                input logic [3:0] d);
        exp_q.push_back({f, o, a});
        drv_q.push_back(d);
    endfunction

    // Builds the whole expected cycle from the record and the peripheral script.
    task automatic build(input logic [47:0] rec, input int waits, input logic [3:0] wait_nib,
                         input int fin, input logic [7:0] rd);
        logic [1:0]  ty;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  wd;
        int          n;
        ty = rec[3:2];
        wr = rec[1];
        a  = rec[47:16];
        wd = rec[15:8];
        exp_q.delete();
        drv_q.delete();
        if (ty > 2'd1) begin
            add(1'b1, 1'b0, 4'hF, 4'hF);
            exp_data   = 8'h00;
            exp_status = 2'd1;
            return;
        end
        add(1'b0, 1'b1, 4'h0, 4'hF);
        add(1'b1, 1'b1, {ty, wr, 1'b0}, 4'hF);
        n = (ty == 2'd0) ? 4 : 8;
        for (int i = n - 1; i >= 0; i--) add(1'b1, 1'b1, a[4*i +: 4], 4'hF);
        if (wr) begin
            add(1'b1, 1'b1, wd[3:0], 4'hF);
            add(1'b1, 1'b1, wd[7:4], 4'hF);
        end
        add(1'b1, 1'b1, 4'hF, 4'hF);
        add(1'b1, 1'b0, 4'hF, 4'hF);
        exp_data = 8'h00;
        if (fin == FIN_TIMEOUT) begin
            for (int i = 0; i < 64; i++) add(1'b1, 1'b0, 4'hF, 4'hF);
            for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 4'hF, 4'hF);
            exp_status = 2'd3;
        end else begin
            for (int i = 0; i < waits; i++) add(1'b1, 1'b0, 4'hF, wait_nib);
            add(1'b1, 1'b0, 4'hF, (fin == FIN_ERR) ? 4'hA : 4'h0);
            if (fin == FIN_READY && !wr) begin
                add(1'b1, 1'b0, 4'hF, rd[3:0]);
                add(1'b1, 1'b0, 4'hF, rd[7:4]);
                exp_data = rd;
            end
            add(1'b1, 1'b0, 4'hF, 4'hF);
            add(1'b1, 1'b0, 4'hF, 4'hF);
            exp_status = (fin == FIN_ERR) ? 2'd2 : 2'd0;
        end
        add(1'b1, 1'b0, 4'hF, 4'hF);
    endtask

    // Offers the record, then follows the expected trace clock by clock.
    task automatic exec_txn(input logic [47:0] rec, input string tag, input bit hold_valid);
        int   t;
        logic last;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(posedge clock); #1;
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: cmd_ready=%b required 1", tag, cmd_ready);
        end
        cmd_data  = rec;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = hold_valid;
        cmd_data  = {$urandom(), 12'($urandom()), 4'b1000};
        for (int i = 0; i < exp_q.size(); i++) begin
            last = (i == exp_q.size() - 1);
            checks++;
            if ({lpc_frame, lpc_ad_oe, lpc_ad_out, resp_valid, cmd_ready} !==
                {exp_q[i], last, 1'b0}) begin
                errors++;
                $display("FAIL %s bus[%0d]: frame/oe/ad/rv/rdy=%b/%b/%h/%b/%b required %b/%b/%h/%b/0",
                         tag, i, lpc_frame, lpc_ad_oe, lpc_ad_out, resp_valid, cmd_ready,
                         exp_q[i][5], exp_q[i][4], exp_q[i][3:0], last);
            end
            if (last) begin
                checks++;
                if ({resp_data, resp_status} !== {exp_data, exp_status}) begin
                    errors++;
                    $display("FAIL %s resp: data=%h status=%0d required data=%h status=%0d",
                             tag, resp_data, resp_status, exp_data, exp_status);
                end
            end
            lpc_ad_in = drv_q[i];
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        lpc_ad_in = 4'hF;
        checks++;
        if ({resp_valid, cmd_ready, lpc_frame, lpc_ad_oe, resp_data, resp_status} !==
            {1'b0, 1'b1, 1'b1, 1'b0, exp_data, exp_status}) begin
            errors++;
            $display("FAIL %s after_done: rv=%b rdy=%b frame=%b oe=%b data=%h status=%0d required 0 1 1 0 %h %0d",
                     tag, resp_valid, cmd_ready, lpc_frame, lpc_ad_oe, resp_data, resp_status,
                     exp_data, exp_status);
        end
        $display("txn %-10s rec=%h clocks=%0d data=%h status=%0d", tag, rec, exp_q.size(),
                 resp_data, resp_status);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        lpc_ad_in = 4'hF;
        #1;
        checks++;
        if ({cmd_ready, lpc_frame, lpc_ad_oe, lpc_ad_out, resp_valid, resp_data, resp_status} !==
            {1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b frame=%b oe=%b ad=%h rv=%b data=%h status=%0d",
                     cmd_ready, lpc_frame, lpc_ad_oe, lpc_ad_out, resp_valid, resp_data, resp_status);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b required 0 before first clock", cmd_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_clock: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_io_write();
        build({32'h0000_0080, 8'h5A, 4'h0, 4'b0010}, 0, 4'h6, FIN_READY, 8'h00);
        exec_txn({32'h0000_0080, 8'h5A, 4'h0, 4'b0010}, "io_write", 1'b0);
    endtask

    task automatic test_mem_read();
        build({32'hFFFF_FFF0, 8'h00, 4'h0, 4'b0100}, 3, 4'h6, FIN_READY, 8'hC4);
        exec_txn({32'hFFFF_FFF0, 8'h00, 4'h0, 4'b0100}, "mem_read", 1'b0);
    endtask

    task automatic test_timeout();
        build({32'h0000_0060, 8'h00, 4'h0, 4'b0000}, 0, 4'hF, FIN_TIMEOUT, 8'h00);
        exec_txn({32'h0000_0060, 8'h00, 4'h0, 4'b0000}, "timeout", 1'b0);
    endtask

    task automatic test_sync_err();
        build({32'h0000_03F8, 8'h33, 4'h0, 4'b0010}, 1, 4'h5, FIN_ERR, 8'h00);
        exec_txn({32'h0000_03F8, 8'h33, 4'h0, 4'b0010}, "sync_err", 1'b0);
    endtask

    task automatic test_unsupported();
        build({32'h1234_5678, 8'h99, 4'h0, 4'b1000}, 0, 4'hF, FIN_READY, 8'h00);
        exec_txn({32'h1234_5678, 8'h99, 4'h0, 4'b1000}, "dma", 1'b0);
    endtask

    // Offers a junk DMA record throughout a cycle; acceptance would show as a DONE.
    task automatic test_back_to_back();
        build({32'h0000_0070, 8'h00, 4'h0, 4'b0000}, 2, 4'h5, FIN_READY, 8'h3B);
        exec_txn({32'h0000_0070, 8'h00, 4'h0, 4'b0000}, "busy_valid", 1'b1);
        build({32'h0000_0071, 8'hE1, 4'h0, 4'b0010}, 0, 4'h5, FIN_READY, 8'h00);
        exec_txn({32'h0000_0071, 8'hE1, 4'h0, 4'b0010}, "b2b_next", 1'b0);
    endtask

    task automatic test_reset_mid_cycle();
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(posedge clock); #1;
            t++;
        end
        cmd_data  = {32'hAAAA_5555, 8'h00, 4'h0, 4'b0100};
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({lpc_frame, lpc_ad_oe, resp_valid, cmd_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid: frame/oe/rv/rdy=%b/%b/%b/%b required 1/0/0/0",
                     lpc_frame, lpc_ad_oe, resp_valid, cmd_ready);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({cmd_ready, resp_valid, lpc_frame, resp_data, resp_status} !==
            {1'b1, 1'b0, 1'b1, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid_release: rdy=%b rv=%b frame=%b data=%h status=%0d required 1 0 1 00 0",
                     cmd_ready, resp_valid, lpc_frame, resp_data, resp_status);
        end
        $display("txn %-10s rec=%h abandoned by reset", "reset_mid", 48'hAAAA_5555_0004);
        build({32'hAAAA_5555, 8'h00, 4'h0, 4'b0100}, 1, 4'h6, FIN_READY, 8'h7E);
        exec_txn({32'hAAAA_5555, 8'h00, 4'h0, 4'b0100}, "after_rst", 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  wait_tab [6];
        logic [47:0] rec;
        int          r;
        int          fin;
        wait_tab = '{4'h5, 4'h6, 4'hF, 4'h1, 4'h3, 4'hC};
        for (int k = 0; k < 24; k++) begin
            rec = {$urandom(), 16'($urandom())};
            r = $urandom_range(0, 5);
            if (r <= 2)      rec[3:2] = 2'b00;
            else if (r <= 4) rec[3:2] = 2'b01;
            else             rec[3:2] = 2'($urandom_range(2, 3));
            r = $urandom_range(0, 11);
            fin = (r == 0) ? FIN_ERR : (r == 1) ? FIN_TIMEOUT : FIN_READY;
            build(rec, $urandom_range(0, 4), wait_tab[$urandom_range(0, 5)], fin,
                  8'($urandom()));
            exec_txn(rec, $sformatf("rand%0d", k), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_io_write();
        test_mem_read();
        test_timeout();
        test_sync_err();
        test_unsupported();
        test_back_to_back();
        test_reset_mid_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
